// File: rtl/philo_pkg.sv
// Shared types for the dining-philosophers ring.
package philo_pkg;

  typedef enum logic [1:0] {
    THINKING = 2'd0,
    HUNGRY   = 2'd1,
    EATING   = 2'd2,
    READING  = 2'd3
  } t_state;

endpackage

// File: rtl/philo_cell.sv
// One philosopher: state machine, hunger wait counter, starvation flag and
// saturating eat counter. Neighbour inputs are the registered ring states.
import philo_pkg::*;

module philo_cell #(
  parameter int MAX_WAIT = 8,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hungry_req,
  input  logic          done_req,
  input  t_state        left_state,
  input  t_state        right_state,
  input  logic          left_starve,
  output t_state        state_o,
  output logic          starve_o,
  output logic [CW-1:0] eat_cnt_o
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  t_state        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          starve_q, starve_d;
  logic [CW-1:0] eat_cnt_q, eat_cnt_d;
  logic          eat_go;

  // Next-state and counter update logic.
  always_comb begin
    state_d   = state_q;
    eat_go    = 1'b0;
    wait_d    = '0;
    starve_d  = 1'b0;
    eat_cnt_d = eat_cnt_q;

    case (state_q)
      THINKING: begin
        if (right_state == READING) state_d = READING;
        else if (hungry_req)        state_d = HUNGRY;
      end
      READING: begin
        if (left_state == THINKING) state_d = THINKING;
      end
      EATING: begin
        if (done_req) state_d = THINKING;
      end
      HUNGRY: begin
        // A starving left neighbour wins the shared fork.
        if ((left_state != EATING) && (right_state != HUNGRY) &&
            (right_state != EATING) && !left_starve) begin
          state_d = EATING;
          eat_go  = 1'b1;
        end
      end
    endcase

    if (state_q == HUNGRY) wait_d = (wait_q == WMAX) ? wait_q : wait_q + 1'b1;

    // Starvation only exists while hungry, and is dropped on the edge into EATING.
    starve_d = (state_q == HUNGRY) && !eat_go && (starve_q || (wait_q == WMAX));

    if (eat_go && (eat_cnt_q != '1)) eat_cnt_d = eat_cnt_q + 1'b1;
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= THINKING;
      wait_q    <= '0;
      starve_q  <= 1'b0;
      eat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      starve_q  <= starve_d;
      eat_cnt_q <= eat_cnt_d;
    end
  end

  assign state_o   = state_q;
  assign starve_o  = starve_q;
  assign eat_cnt_o = eat_cnt_q;

endmodule

// File: rtl/philo_ring.sv
// Ring of N philosophers; left = (i+1) mod N, right = (i+N-1) mod N.
import philo_pkg::*;

module philo_ring #(
  parameter int N        = 5,
  parameter int MAX_WAIT = 8,
  parameter int CW       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    hungry_req,
  input  logic [N-1:0]    done_req,
  output logic [2*N-1:0]  state_o,
  output logic [N-1:0]    starve_o,
  output logic [N*CW-1:0] eat_cnt_o,
  output logic            any_starve_o
);

  t_state       st [N];
  logic [N-1:0] starve;

  for (genvar i = 0; i < N; i++) begin : g_cell
    localparam int L = (i + 1) % N;
    localparam int R = (i + N - 1) % N;

    philo_cell #(
      .MAX_WAIT(MAX_WAIT),
      .CW      (CW)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .hungry_req (hungry_req[i]),
      .done_req   (done_req[i]),
      .left_state (st[L]),
      .right_state(st[R]),
      .left_starve(starve[L]),
      .state_o    (st[i]),
      .starve_o   (starve[i]),
      .eat_cnt_o  (eat_cnt_o[CW*i +: CW])
    );

    assign state_o[2*i +: 2] = st[i];
  end

  assign starve_o     = starve;
  assign any_starve_o = |starve;

endmodule

// File: tb/tb_philo_ring.sv
// Directed and random checks for philo_ring.
import philo_pkg::*;

module tb_philo_ring;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main directed DUT: N=5, MAX_WAIT=4, CW=2 (small CW exposes saturation).
  logic [4:0] hungry_req, done_req, starve_o;
  logic [9:0] state_o, eat_cnt_o;
  logic       any_starve_o;

  philo_ring #(.N(5), .MAX_WAIT(4), .CW(2)) dut (
    .clk(clk), .rst_n(rst_n), .hungry_req(hungry_req), .done_req(done_req),
    .state_o(state_o), .starve_o(starve_o), .eat_cnt_o(eat_cnt_o),
    .any_starve_o(any_starve_o));

  logic [2:0]  hr3, dr3, sv3;
  logic [5:0]  so3;
  logic [23:0] ec3;
  logic        a3;
  philo_ring #(.N(3), .MAX_WAIT(3), .CW(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .hungry_req(hr3), .done_req(dr3),
    .state_o(so3), .starve_o(sv3), .eat_cnt_o(ec3), .any_starve_o(a3));

  logic [63:0]  hr64, dr64, sv64;
  logic [127:0] so64;
  logic [511:0] ec64;
  logic         a64;
  philo_ring #(.N(64), .MAX_WAIT(8), .CW(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .hungry_req(hr64), .done_req(dr64),
    .state_o(so64), .starve_o(sv64), .eat_cnt_o(ec64), .any_starve_o(a64));

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    hungry_req = '0; done_req = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; hungry_req = '0; done_req = '0;
    #2 rst_n = 1'b0;
    #2;
    checks++; if (state_o !== 10'd0) begin errors++; $display("FAIL reset_state: got %b expected %b", state_o, 10'd0); end
    checks++; if (starve_o !== 5'd0) begin errors++; $display("FAIL reset_starve: got %b expected %b", starve_o, 5'd0); end
    checks++; if (eat_cnt_o !== 10'd0) begin errors++; $display("FAIL reset_cnt: got %b expected %b", eat_cnt_o, 10'd0); end
    checks++; if (any_starve_o !== 1'b0) begin errors++; $display("FAIL reset_any: got %b expected 0", any_starve_o); end
    hungry_req = '1;
    step(); step();
    checks++; if (state_o !== 10'd0) begin errors++; $display("FAIL reset_held: got %b expected %b", state_o, 10'd0); end
    hungry_req = '0;
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_eater();
    do_reset();
    hungry_req = 5'b00001;
    step();
    checks++; if (state_o !== 10'b00_00_00_00_01) begin errors++; $display("FAIL single_hungry: got %b expected %b", state_o, 10'b00_00_00_00_01); end
    hungry_req = '0; done_req = 5'b00001;   // ignored while HUNGRY
    step();
    checks++; if (state_o !== 10'b00_00_00_00_10) begin errors++; $display("FAIL single_eat: got %b expected %b", state_o, 10'b00_00_00_00_10); end
    checks++; if (eat_cnt_o !== 10'b00_00_00_00_01) begin errors++; $display("FAIL single_cnt: got %b expected %b", eat_cnt_o, 10'b00_00_00_00_01); end
    done_req = '0; hungry_req = 5'b00001;   // ignored while EATING
    step();
    checks++; if (state_o !== 10'b00_00_00_00_10) begin errors++; $display("FAIL single_hold: got %b expected %b", state_o, 10'b00_00_00_00_10); end
    hungry_req = '0; done_req = 5'b00001;
    step();
    done_req = '0;
    checks++; if (state_o !== 10'd0) begin errors++; $display("FAIL single_done: got %b expected %b", state_o, 10'd0); end
    checks++; if (eat_cnt_o !== 10'b00_00_00_00_01) begin errors++; $display("FAIL single_cnt_keep: got %b expected %b", eat_cnt_o, 10'b00_00_00_00_01); end
  endtask

  task automatic test_exclusion();
    do_reset();
    hungry_req = 5'b00011;
    step();
    checks++; if (state_o !== 10'b00_00_00_01_01) begin errors++; $display("FAIL excl_c1: got %b expected %b", state_o, 10'b00_00_00_01_01); end
    hungry_req = '0;
    step();
    checks++; if (state_o !== 10'b00_00_00_01_10) begin errors++; $display("FAIL excl_c2: got %b expected %b", state_o, 10'b00_00_00_01_10); end
    step(); step(); step();
    checks++; if (starve_o !== 5'b00000) begin errors++; $display("FAIL excl_nostarve_c5: got %b expected %b", starve_o, 5'b00000); end
    step();
    checks++; if (starve_o !== 5'b00010) begin errors++; $display("FAIL excl_starve_c6: got %b expected %b", starve_o, 5'b00010); end
    checks++; if (any_starve_o !== 1'b1) begin errors++; $display("FAIL excl_any_c6: got %b expected 1", any_starve_o); end
    checks++; if (state_o !== 10'b00_00_00_01_10) begin errors++; $display("FAIL excl_c6: got %b expected %b", state_o, 10'b00_00_00_01_10); end
    done_req = 5'b00001;
    step();
    done_req = '0;
    checks++; if (state_o !== 10'b00_00_00_01_00) begin errors++; $display("FAIL excl_c7: got %b expected %b", state_o, 10'b00_00_00_01_00); end
    checks++; if (starve_o !== 5'b00010) begin errors++; $display("FAIL excl_starve_c7: got %b expected %b", starve_o, 5'b00010); end
    step();
    checks++; if (state_o !== 10'b00_00_00_10_00) begin errors++; $display("FAIL excl_c8: got %b expected %b", state_o, 10'b00_00_00_10_00); end
    checks++; if (starve_o !== 5'b00000) begin errors++; $display("FAIL excl_starve_c8: got %b expected %b", starve_o, 5'b00000); end
    checks++; if (any_starve_o !== 1'b0) begin errors++; $display("FAIL excl_any_c8: got %b expected 0", any_starve_o); end
    checks++; if (eat_cnt_o !== 10'b00_00_00_01_01) begin errors++; $display("FAIL excl_cnt: got %b expected %b", eat_cnt_o, 10'b00_00_00_01_01); end
    // Wrap-around: ph0's right neighbour is ph4.
    do_reset();
    hungry_req = 5'b10001;
    step();
    hungry_req = '0;
    step();
    checks++; if (state_o !== 10'b10_00_00_00_01) begin errors++; $display("FAIL excl_wrap: got %b expected %b", state_o, 10'b10_00_00_00_01); end
  endtask

  task automatic test_aging();
    do_reset();
    hungry_req = 5'b00010;
    step();
    hungry_req = 5'b00100;
    step();
    checks++; if (state_o !== 10'b00_00_01_10_00) begin errors++; $display("FAIL aging_c2: got %b expected %b", state_o, 10'b00_00_01_10_00); end
    hungry_req = '0;
    step(); step(); step(); step();
    hungry_req = 5'b01000;
    step();
    hungry_req = '0;
    checks++; if (state_o !== 10'b00_01_01_10_00) begin errors++; $display("FAIL aging_c7: got %b expected %b", state_o, 10'b00_01_01_10_00); end
    checks++; if (starve_o !== 5'b00100) begin errors++; $display("FAIL aging_starve_c7: got %b expected %b", starve_o, 5'b00100); end
    done_req = 5'b00010;
    step();
    done_req = '0;
    checks++; if (state_o !== 10'b00_01_01_00_00) begin errors++; $display("FAIL aging_c8: got %b expected %b", state_o, 10'b00_01_01_00_00); end
    step();
    checks++; if (state_o !== 10'b00_01_10_00_00) begin errors++; $display("FAIL aging_c9: got %b expected %b", state_o, 10'b00_01_10_00_00); end
    checks++; if (starve_o !== 5'b00000) begin errors++; $display("FAIL aging_starve_c9: got %b expected %b", starve_o, 5'b00000); end
    checks++; if (eat_cnt_o !== 10'b00_00_01_01_00) begin errors++; $display("FAIL aging_cnt_c9: got %b expected %b", eat_cnt_o, 10'b00_00_01_01_00); end
    done_req = 5'b00100;
    step();
    done_req = '0;
    step();
    checks++; if (state_o !== 10'b00_10_00_00_00) begin errors++; $display("FAIL aging_c11: got %b expected %b", state_o, 10'b00_10_00_00_00); end
    // Starving left neighbour (ph3) blocks an otherwise free ph2.
    do_reset();
    hungry_req = 5'b10000;
    step();
    hungry_req = 5'b01000;
    step();
    hungry_req = '0;
    checks++; if (state_o !== 10'b10_01_00_00_00) begin errors++; $display("FAIL block_c2: got %b expected %b", state_o, 10'b10_01_00_00_00); end
    step(); step(); step(); step();
    hungry_req = 5'b00100;
    step();
    hungry_req = '0;
    checks++; if (starve_o !== 5'b01000) begin errors++; $display("FAIL block_starve_c7: got %b expected %b", starve_o, 5'b01000); end
    step();
    checks++; if (state_o !== 10'b10_01_01_00_00) begin errors++; $display("FAIL block_c8: got %b expected %b", state_o, 10'b10_01_01_00_00); end
    step();
    checks++; if (state_o !== 10'b10_01_01_00_00) begin errors++; $display("FAIL block_c9: got %b expected %b", state_o, 10'b10_01_01_00_00); end
  endtask

  task automatic test_reading();
    do_reset();
    force dut.g_cell[1].u_cell.state_q = READING;
    force dut.g_cell[3].u_cell.state_q = READING;
    step();
    checks++; if (state_o !== 10'b11_11_11_11_00) begin errors++; $display("FAIL read_c1: got %b expected %b", state_o, 10'b11_11_11_11_00); end
    step();
    checks++; if (state_o !== 10'b00_11_11_11_11) begin errors++; $display("FAIL read_c2: got %b expected %b", state_o, 10'b00_11_11_11_11); end
    step();
    checks++; if (state_o !== 10'b11_11_11_11_11) begin errors++; $display("FAIL read_c3: got %b expected %b", state_o, 10'b11_11_11_11_11); end
    step();
    checks++; if (state_o !== 10'b11_11_11_11_11) begin errors++; $display("FAIL read_c4: got %b expected %b", state_o, 10'b11_11_11_11_11); end
    force dut.g_cell[1].u_cell.state_q = THINKING;
    step();
    checks++; if (state_o !== 10'b11_11_11_00_00) begin errors++; $display("FAIL read_c5: got %b expected %b", state_o, 10'b11_11_11_00_00); end
    release dut.g_cell[1].u_cell.state_q;
    release dut.g_cell[3].u_cell.state_q;
    do_reset();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      exp_cnt = (k > 3) ? 2'd3 : 2'(k);
      hungry_req = 5'b00001;
      step();
      hungry_req = '0;
      step();
      checks++; if (eat_cnt_o[1:0] !== exp_cnt) begin errors++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, eat_cnt_o[1:0], exp_cnt); end
      done_req = 5'b00001;
      step();
      done_req = '0;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    hungry_req = 5'b00011;
    step();
    hungry_req = '0;
    repeat (5) step();
    checks++; if (any_starve_o !== 1'b1) begin errors++; $display("FAIL arst_pre_any: got %b expected 1", any_starve_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state_o !== 10'd0) begin errors++; $display("FAIL arst_state: got %b expected %b", state_o, 10'd0); end
    checks++; if (starve_o !== 5'd0) begin errors++; $display("FAIL arst_starve: got %b expected %b", starve_o, 5'd0); end
    checks++; if (eat_cnt_o !== 10'd0) begin errors++; $display("FAIL arst_cnt: got %b expected %b", eat_cnt_o, 10'd0); end
    checks++; if (any_starve_o !== 1'b0) begin errors++; $display("FAIL arst_any: got %b expected 0", any_starve_o); end
    @(negedge clk); rst_n = 1'b1;
    hungry_req = 5'b00001;
    step();
    hungry_req = '0;
    checks++; if (state_o !== 10'b00_00_00_00_01) begin errors++; $display("FAIL arst_resume: got %b expected %b", state_o, 10'b00_00_00_00_01); end
  endtask

  task automatic test_random();
    logic bad;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      hr3 = 3'($urandom); dr3 = 3'($urandom);
      hr64 = {$urandom, $urandom}; dr64 = {$urandom, $urandom};
      step();
      bad = 1'b0;
      for (int i = 0; i < 3; i++)
        if (so3[2*i +: 2] == 2'd2 && so3[2*((i+1)%3) +: 2] == 2'd2) bad = 1'b1;
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rand3_adjacent_eat: cycle %0d state %b", c, so3); end
      checks++; if (a3 !== (|sv3)) begin errors++; $display("FAIL rand3_any: got %b expected %b", a3, |sv3); end
      bad = 1'b0;
      for (int i = 0; i < 64; i++)
        if (so64[2*i +: 2] == 2'd2 && so64[2*((i+1)%64) +: 2] == 2'd2) bad = 1'b1;
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rand64_adjacent_eat: cycle %0d state %h", c, so64); end
      checks++; if (a64 !== (|sv64)) begin errors++; $display("FAIL rand64_any: got %b expected %b", a64, |sv64); end
    end
    hr3 = '0; dr3 = '0; hr64 = '0; dr64 = '0;
  endtask

  initial begin
    hr3 = '0; dr3 = '0; hr64 = '0; dr64 = '0;
    test_reset();
    test_single_eater();
    test_exclusion();
    test_aging();
    test_reading();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
